// File: rtl/pipeline_hazard_stall_unit.sv
// rtl/pipeline_hazard_stall_unit.sv - ID-stage stall/bubble generator with shadow writer scoreboard
// Optional build macro: HAZARD_FORWARDING_EN (stall only on load-use when EX/MEM->EX forwarding exists)
module pipeline_hazard_stall_unit #(
  parameter int MULDIV_CYCLES         = 4,
  parameter int REGFILE_WRITE_THROUGH = 1,
  parameter int PERF_WIDTH            = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs_addr,
  input  logic                  id_rs_read,
  input  logic [4:0]            id_rt_addr,
  input  logic                  id_rt_read,
  input  logic [4:0]            id_rd_addr,
  input  logic                  id_rd_write_enable,
  input  logic                  id_is_load,
  input  logic                  id_is_muldiv,
  input  logic                  id_flush,
  output logic                  pause,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  muldiv_busy,
  output logic [PERF_WIDTH-1:0] stall_cycles
);

  typedef struct packed {
    logic       wen;
    logic [4:0] addr;
    logic       load;
  } sb_entry_t;

  localparam logic [3:0] BUSY_LOAD = 4'(MULDIV_CYCLES - 1);

  sb_entry_t  sb_ex, sb_mem, sb_wb;
  logic [3:0] busy_cnt;
  logic       hazard;
  logic       issue;
  logic       unused_bits;

  function automatic logic src_match(input logic rd, input logic [4:0] a, input sb_entry_t e);
    return rd && (a != 5'd0) && e.wen && (e.addr == a);
  endfunction

  logic hit_ex;
  assign hit_ex = src_match(id_rs_read, id_rs_addr, sb_ex) | src_match(id_rt_read, id_rt_addr, sb_ex);

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers everything except a load whose data is not back yet
  assign hazard      = id_valid & hit_ex & sb_ex.load;
  assign unused_bits = ^{sb_mem, sb_wb};
`else
  localparam logic CHECK_WB = (REGFILE_WRITE_THROUGH == 0);
  logic hit_mem, hit_wb;
  assign hit_mem = src_match(id_rs_read, id_rs_addr, sb_mem) | src_match(id_rt_read, id_rt_addr, sb_mem);
  assign hit_wb  = src_match(id_rs_read, id_rs_addr, sb_wb)  | src_match(id_rt_read, id_rt_addr, sb_wb);
  assign hazard      = id_valid & (hit_ex | hit_mem | (CHECK_WB & hit_wb));
  assign unused_bits = ^{sb_ex.load, sb_mem.load, sb_wb.load};
`endif

  assign muldiv_busy = (busy_cnt != 4'd0);
  assign pc_hold     = ~reset & (muldiv_busy | (hazard & ~id_flush));
  assign if_id_hold  = pc_hold;
  assign pause       = reset | muldiv_busy | hazard | id_flush;
  assign issue       = id_valid & ~pause;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_ex        <= '0;
      sb_mem       <= '0;
      sb_wb        <= '0;
      busy_cnt     <= 4'd0;
      stall_cycles <= '0;
    end else begin
      if (pc_hold && (stall_cycles != {PERF_WIDTH{1'b1}}))
        stall_cycles <= stall_cycles + PERF_WIDTH'(1);
      if (muldiv_busy) begin
        // mul/div parks in EX; a bubble drains into MEM behind it
        sb_wb    <= sb_mem;
        sb_mem   <= '0;
        busy_cnt <= busy_cnt - 4'd1;
      end else begin
        sb_wb    <= sb_mem;
        sb_mem   <= sb_ex;
        sb_ex    <= issue ? '{wen: id_rd_write_enable, addr: id_rd_addr, load: id_is_load} : '0;
        busy_cnt <= (issue && id_is_muldiv) ? BUSY_LOAD : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_stall_unit.sv
// tb/tb_pipeline_hazard_stall_unit.sv - directed + randomized check of pipeline_hazard_stall_unit against a stage-age model
module tb_pipeline_hazard_stall_unit;

  localparam int MULDIV_CYCLES = 4;
  localparam int WT            = 1;
  localparam int PW            = 16;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          id_valid, id_rs_read, id_rt_read, id_rd_write_enable;
  logic          id_is_load, id_is_muldiv, id_flush;
  logic [4:0]    id_rs_addr, id_rt_addr, id_rd_addr;
  logic          pause, pc_hold, if_id_hold, muldiv_busy;
  logic [PW-1:0] stall_cycles;

  pipeline_hazard_stall_unit #(
    .MULDIV_CYCLES(MULDIV_CYCLES), .REGFILE_WRITE_THROUGH(WT), .PERF_WIDTH(PW)
  ) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rs_read(id_rs_read),
    .id_rt_addr(id_rt_addr), .id_rt_read(id_rt_read),
    .id_rd_addr(id_rd_addr), .id_rd_write_enable(id_rd_write_enable),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .id_flush(id_flush),
    .pause(pause), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  // Second instance with long mul/div occupancy drives the saturating counter
  logic          s_reset, s_valid, s_muldiv;
  logic          s_pause, s_hold, s_ifid, s_busy;
  logic [PW-1:0] s_stall;

  pipeline_hazard_stall_unit #(
    .MULDIV_CYCLES(15), .REGFILE_WRITE_THROUGH(WT), .PERF_WIDTH(PW)
  ) dut_sat (
    .clock(clock), .reset(s_reset), .id_valid(s_valid),
    .id_rs_addr(5'd0), .id_rs_read(1'b0), .id_rt_addr(5'd0), .id_rt_read(1'b0),
    .id_rd_addr(5'd0), .id_rd_write_enable(1'b0), .id_is_load(1'b0),
    .id_is_muldiv(s_muldiv), .id_flush(1'b0),
    .pause(s_pause), .pc_hold(s_hold), .if_id_hold(s_ifid),
    .muldiv_busy(s_busy), .stall_cycles(s_stall)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_instr(input bit v, input int rs, input bit rsr, input int rt, input bit rtr,
                           input int rd, input bit rdw, input bit ld, input bit md, input bit fl);
    id_valid = v; id_rs_addr = 5'(rs); id_rs_read = rsr; id_rt_addr = 5'(rt); id_rt_read = rtr;
    id_rd_addr = 5'(rd); id_rd_write_enable = rdw; id_is_load = ld; id_is_muldiv = md; id_flush = fl;
  endtask

  task automatic cyc(input bit v, input int rs, input bit rsr, input int rt, input bit rtr,
                     input int rd, input bit rdw, input bit ld, input bit md, input bit fl);
    @(negedge clock);
    set_instr(v, rs, rsr, rt, rtr, rd, rdw, ld, md, fl);
    #1;
  endtask

  task automatic drain();
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: list of in-flight writers tagged with their pipeline stage (1=EX, 2=MEM, 3=WB)
  typedef struct {
    int stage;
    bit wen;
    int addr;
    bit load;
  } item_t;
  item_t inflight[$];
  int    m_busy_left;
  int    m_stall;

  task automatic m_reset();
    inflight.delete();
    m_busy_left = 0;
    m_stall     = 0;
  endtask

  function automatic bit m_hazard();
    bit m;
    if (!id_valid) return 1'b0;
    foreach (inflight[i]) begin
      if (!inflight[i].wen || inflight[i].addr == 0) continue;
      m = (id_rs_read && int'(id_rs_addr) == inflight[i].addr) ||
          (id_rt_read && int'(id_rt_addr) == inflight[i].addr);
      if (FWD) begin
        if (m && inflight[i].stage == 1 && inflight[i].load) return 1'b1;
      end else begin
        if (m && inflight[i].stage <= (WT != 0 ? 2 : 3)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic m_clock(input bit hold, input bit busy, input bit pz);
    item_t nq[$];
    item_t it;
    if (hold && m_stall < (2**PW - 1)) m_stall++;
    foreach (inflight[i]) begin
      it = inflight[i];
      if (!(busy && it.stage == 1)) it.stage++;
      if (it.stage <= 3) nq.push_back(it);
    end
    if (id_valid && !pz) begin
      it = '{stage: 1, wen: id_rd_write_enable, addr: int'(id_rd_addr), load: id_is_load};
      nq.push_back(it);
      if (id_is_muldiv) m_busy_left = MULDIV_CYCLES - 1;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end
    inflight = nq;
  endtask

  initial begin
    bit e_busy, e_hz, e_hold, e_pause;

    reset = 1'b1;
    s_reset = 1'b1; s_valid = 1'b1; s_muldiv = 1'b1;
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
    exp_stall = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      check("rst_pause", pause, 1);
      check("rst_pc_hold", pc_hold, 0);
      check("rst_if_id_hold", if_id_hold, 0);
      check("rst_stall", stall_cycles, 0);
    end

    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      reset = 1'b0;
      set_instr(1, i + 8, 1, i + 16, 1, i, 1, 0, 0, 0);
      #1;
      check("indep_pause", pause, 0);
    end

    // ALU producer then dependent consumer
    drain();
    cyc(1, 20, 1, 21, 1, 3, 1, 0, 0, 0);
    check("raw_prod_pause", pause, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 3, 1, 22, 1, 6, 1, 0, 0, 0);
      check("raw_pause", pause, (!FWD && k < 2));
      check("raw_pc_hold", pc_hold, (!FWD && k < 2));
    end
    exp_stall += FWD ? 0 : 2;
    check("raw_stall", stall_cycles, exp_stall);

    // load producer then dependent consumer
    drain();
    cyc(1, 20, 1, 21, 1, 4, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4, 1, 0, 0, 8, 1, 0, 0, 0);
      check("ldu_pause", pause, k < (FWD ? 1 : 2));
    end
    exp_stall += FWD ? 1 : 2;
    check("ldu_stall", stall_cycles, exp_stall);

    drain();
    cyc(1, 20, 1, 21, 1, 0, 1, 0, 0, 0);
    check("r0_writer_pause", pause, 0);
    cyc(1, 0, 1, 0, 1, 12, 1, 0, 0, 0);
    check("r0_reader_pause", pause, 0);

    // mul/div occupancy with a flush arriving mid-busy
    drain();
    cyc(1, 20, 1, 21, 1, 7, 1, 0, 1, 0);
    check("md_issue_busy", muldiv_busy, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 22, 1, 23, 1, 9, 1, 0, 0, (k == 1));
      check("md_busy", muldiv_busy, 1);
      check("md_pc_hold", pc_hold, 1);
      check("md_if_id_hold", if_id_hold, 1);
      check("md_pause", pause, 1);
    end
    cyc(1, 22, 1, 23, 1, 9, 1, 0, 0, 0);
    check("md_done_busy", muldiv_busy, 0);
    check("md_done_pause", pause, 0);
    exp_stall += 3;
    check("md_stall", stall_cycles, exp_stall);

    // reset during busy clears at once
    drain();
    cyc(1, 20, 1, 21, 1, 7, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mdr_busy_before", muldiv_busy, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mdr_busy", muldiv_busy, 0);
    check("mdr_pause", pause, 1);
    check("mdr_stall", stall_cycles, 0);
    exp_stall = 0;
    @(negedge clock);
    reset = 1'b0;
    set_instr(1, 7, 1, 7, 1, 13, 1, 0, 0, 0);
    #1;
    check("mdr_after_pause", pause, 0);
    check("mdr_after_hold", pc_hold, 0);

    // hazard coinciding with flush: bubble, no hold, no scoreboard entry
    drain();
    cyc(1, 20, 1, 21, 1, 9, 1, 0, 0, 0);
    cyc(1, 9, 1, 0, 0, 10, 1, 0, 0, 1);
    check("flush_pause", pause, 1);
    check("flush_pc_hold", pc_hold, !FWD ? 0 : 0);
    cyc(1, 10, 1, 0, 0, 11, 1, 0, 0, 0);
    check("flush_next_pause", pause, 0);
    check("flush_stall", stall_cycles, exp_stall);

    // randomized run against the stage-age model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset = (c == 0) || ($urandom_range(0, 299) == 0);
      id_valid           = ($urandom_range(0, 7) != 0);
      id_rs_addr         = 5'($urandom_range(0, 3));
      id_rt_addr         = 5'($urandom_range(0, 3));
      id_rd_addr         = 5'($urandom_range(0, 3));
      id_rs_read         = 1'($urandom);
      id_rt_read         = 1'($urandom);
      id_rd_write_enable = ($urandom_range(0, 3) != 0);
      id_is_load         = ($urandom_range(0, 3) == 0);
      id_is_muldiv       = ($urandom_range(0, 9) == 0);
      id_flush           = ($urandom_range(0, 9) == 0);
      if (reset) m_reset();
      #1;
      e_busy  = (m_busy_left > 0);
      e_hz    = m_hazard();
      e_hold  = !reset && (e_busy || (e_hz && !id_flush));
      e_pause = reset || e_busy || e_hz || id_flush;
      check("rnd_pause", pause, e_pause);
      check("rnd_pc_hold", pc_hold, e_hold);
      check("rnd_if_id_hold", if_id_hold, e_hold);
      check("rnd_busy", muldiv_busy, e_busy);
      check("rnd_stall", stall_cycles, m_stall);
      if (!reset) m_clock(e_hold, e_busy, e_pause);
    end

    // saturation: 14 hold cycles per 15-cycle mul/div period
    @(negedge clock);
    s_reset = 1'b0;
    repeat (150) @(posedge clock);
    @(negedge clock); #1;
    check("sat_partial", s_stall, 140);
    repeat (74950) @(posedge clock);
    @(negedge clock); #1;
    check("sat_full", s_stall, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_stall_unit.md
Name: pipeline_hazard_stall_unit

Overview:
- Generates the `pause` input of the ID/EX pipeline register, plus the PC and IF/ID hold signals.
- Sits beside the ID stage.
- Tracks in-flight register writers in a shadow scoreboard that mirrors the EX/MEM/WB pipeline.
- Detects RAW and load-use hazards and sequences multi-cycle mul/div occupancy.
- Flushes ID on taken branches by forcing a bubble into ID/EX.

Parameters:
- MULDIV_CYCLES, 4: EX occupancy of a mul/div instruction in cycles. Legal range 2..15.
- REGFILE_WRITE_THROUGH, 1: when 1, the register file forwards a WB-stage write to a same-cycle ID read, so WB is excluded from hazard checks.
- PERF_WIDTH, 16: width of the saturating stall-cycle counter.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  5  source register rs
- id_rs_read  in  1  instruction reads rs
- id_rt_addr  in  5  source register rt
- id_rt_read  in  1  instruction reads rt
- id_rd_addr  in  5  destination register
- id_rd_write_enable  in  1  instruction writes rd
- id_is_load  in  1  dmem read (dmem enable and not dmem write enable)
- id_is_muldiv  in  1  multi-cycle EX operation
- id_flush  in  1  taken branch; discard the ID instruction
- pause  out  1  to ID/EX register; 1 inserts a bubble
- pc_hold  out  1  freeze PC
- if_id_hold  out  1  freeze IF/ID register
- muldiv_busy  out  1  mul/div occupying EX
- stall_cycles  out  PERF_WIDTH  count of cycles with pc_hold=1, saturating

Behaviour:
- Reset: already decided — reset is `reset`, asynchronous, active-high; clock is `clock`.
  - While reset=1: scoreboard entries are invalid, busy counter=0, stall_cycles=0, pause=1, pc_hold=0, if_id_hold=0, muldiv_busy=0.
- Scoreboard:
  - Three entries: EX, MEM, WB. Each holds {wen, addr[4:0], load}.
  - Each posedge: WB<=MEM, MEM<=EX.
  - EX<={id_rd_write_enable, id_rd_addr, id_is_load} when issue=id_valid&~pause, else EX<=0. This mirrors the bubble the ID/EX register inserts.
  - While muldiv_busy=1, EX/MEM/WB do not shift. EX holds the mul/div entry and MEM<=0 each cycle.
- Match rule:
  - A source matches an entry when read=1, addr!=0, entry.wen=1 and entry.addr==src addr.
  - Register 0 never causes a hazard.
- hazard (no forwarding build):
  - Any rs/rt match against EX or MEM.
  - Also WB when REGFILE_WRITE_THROUGH=0.
  - Qualified by id_valid.
- Busy counter (4 bits):
  - Loaded with MULDIV_CYCLES-1 on an issue with id_is_muldiv=1.
  - Decrements while nonzero.
  - muldiv_busy = (counter!=0).
  - A mul/div issued back-to-back after busy drops is legal.
- Outputs are combinational from the current inputs and registered state; zero latency.
  - pc_hold = if_id_hold = muldiv_busy | (hazard & ~id_flush).
  - pause = muldiv_busy | hazard | id_flush.
- Flush:
  - id_flush=1 with a hazard: bubble inserted, no hold, no scoreboard entry.
  - id_flush=1 during busy: busy dominates all holds.
- Perf counter: stall_cycles increments on each posedge with pc_hold=1 and saturates at all-ones.
- Reset mid-mul/div: counter and scoreboard clear immediately; the next cycle after reset release has no hazards.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined:
  - The datapath has EX/MEM->EX forwarding.
  - hazard is only a load-use hazard: an rs/rt match against the EX entry with load=1.
  - MEM/WB matches never stall.
  - Exactly 1 bubble per load-use hazard.
- Undefined: full RAW stall as above.
  - Dependent ALU op directly behind a writer stalls 2 cycles with REGFILE_WRITE_THROUGH=1, 3 cycles with 0.

Test Plan:
- Reset held 3 cycles with id_valid=1 -> pause=1, holds=0, stall_cycles=0. After release, independent stream r1..r5 -> pause=0 every cycle.
- No forwarding, default params: `add r3` then `sub` reading r3 -> pc_hold=1 and pause=1 for exactly 2 cycles, issue on the 3rd, stall_cycles=2.
- HAZARD_FORWARDING_EN: `lw r4` then `add` reading r4 -> exactly 1 bubble. Same pair with `add r4` as producer -> 0 bubbles.
- Writer to r0 followed by a reader of r0 -> no stall in either build.
- Mul/div issued with MULDIV_CYCLES=4 -> muldiv_busy=1 for 3 cycles, holds=1 for 3 cycles. id_flush during busy keeps holds=1. Assert reset mid-busy -> muldiv_busy=0 immediately.
- Hazard and id_flush in the same cycle -> pause=1, pc_hold=0. Next cycle no residual stall. Force 70000 hold cycles with PERF_WIDTH=16 -> stall_cycles=0xFFFF.
